// File: rtl/tdm_demux.sv
// tdm_demux: TDM receive demultiplexer, publishes one parallel word per completed frame.
// Optional TDM_DEMUX_CH_STROBE_EN adds ch_strobe, a registered per-slot accept pulse.
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 8,
  parameter int SLOT_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      sof,
  output logic [CHANNELS*WIDTH-1:0] ch_data,
  output logic                      frame_valid,
  output logic [SLOT_W-1:0]         slot,
  output logic                      locked,
  output logic                      sync_err
`ifdef TDM_DEMUX_CH_STROBE_EN
  ,
  output logic [CHANNELS-1:0]       ch_strobe
`endif
);
  typedef enum logic {HUNT, RUN} state_t;
  state_t state, state_n;
  logic [SLOT_W-1:0] slot_n, wslot;
  logic [(CHANNELS-1)*WIDTH-1:0] shadow, shadow_n;
  logic [CHANNELS*WIDTH-1:0] ch_data_n;
  logic accept, last, err;
`ifdef TDM_DEMUX_CH_STROBE_EN
  logic [CHANNELS-1:0] strobe_n;
`endif
  assign locked = state == RUN;
  // sof always restarts at slot 0; slot is 0 throughout HUNT so it also gates acceptance there
  always_comb begin
    accept = din_valid && (sof || (state == RUN && slot != '0));
    err = din_valid && state == RUN && (sof ? slot != '0 : slot == '0);
    wslot = sof ? '0 : slot;
    last = accept && wslot == SLOT_W'(CHANNELS - 1);
    state_n = (din_valid && sof) ? RUN : err ? HUNT : state;
    slot_n = accept ? wslot + 1'b1 : slot;
    shadow_n = shadow;
    for (int k = 0; k < CHANNELS - 1; k++)
      if (accept && wslot == SLOT_W'(k)) shadow_n[k*WIDTH +: WIDTH] = din;
    ch_data_n = last ? {din, shadow} : ch_data;
`ifdef TDM_DEMUX_CH_STROBE_EN
    strobe_n = accept ? CHANNELS'(1) << wslot : '0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT;
      slot <= '0;
      shadow <= '0;
      ch_data <= '0;
      frame_valid <= 1'b0;
      sync_err <= 1'b0;
`ifdef TDM_DEMUX_CH_STROBE_EN
      ch_strobe <= '0;
`endif
    end else begin
      state <= state_n;
      slot <= slot_n;
      shadow <= shadow_n;
      ch_data <= ch_data_n;
      frame_valid <= last;
      sync_err <= err;
`ifdef TDM_DEMUX_CH_STROBE_EN
      ch_strobe <= strobe_n;
`endif
    end
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed and random checks of tdm_demux against a frame-level queue model.
module tb_tdm_demux;
  localparam int CH = 4;
  localparam int W = 8;
`ifdef TDM_DEMUX_CH_STROBE_EN
  localparam int OW = CH*W + 5 + CH;
`else
  localparam int OW = CH*W + 5;
`endif
  logic clk = 0, rst_n = 0, din_valid = 0, sof = 0;
  logic [W-1:0] din = '0;
  logic [CH*W-1:0] ch_data;
  logic frame_valid, locked, sync_err;
  logic [1:0] slot;
  logic [OW-1:0] obs;
  int n_chk = 0, n_fail = 0;
  logic m_locked, m_fv, m_err;
  logic [CH*W-1:0] m_data;
  logic [CH-1:0] m_strobe;
  logic [W-1:0] m_q[$];

`ifdef TDM_DEMUX_CH_STROBE_EN
  logic [CH-1:0] ch_strobe;
  assign obs = {ch_data, frame_valid, sync_err, slot, locked, ch_strobe};
`else
  assign obs = {ch_data, frame_valid, sync_err, slot, locked};
`endif

  tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .ch_data(ch_data), .frame_valid(frame_valid), .slot(slot), .locked(locked),
`ifdef TDM_DEMUX_CH_STROBE_EN
    .ch_strobe(ch_strobe),
`endif
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] exp_vec();
`ifdef TDM_DEMUX_CH_STROBE_EN
    return {m_data, m_fv, m_err, 2'(m_q.size()), m_locked, m_strobe};
`else
    return {m_data, m_fv, m_err, 2'(m_q.size()), m_locked};
`endif
  endfunction

  task automatic model_reset();
    m_locked = 0; m_fv = 0; m_err = 0; m_data = '0; m_strobe = '0; m_q = {};
  endtask

  // A frame is a list of samples gathered since the last sof; it publishes once CH are collected.
  task automatic model_step(input logic v, input logic s, input logic [W-1:0] d);
    m_fv = 0; m_err = 0; m_strobe = '0;
    if (v) begin
      if (s) begin
        if (m_locked && m_q.size() != 0) m_err = 1;
        m_locked = 1; m_q = {d}; m_strobe = 1;
      end else if (m_locked && m_q.size() == 0) begin
        m_err = 1; m_locked = 0;
      end else if (m_locked) begin
        m_strobe = CH'(1) << m_q.size();
        m_q.push_back(d);
        if (m_q.size() == CH) begin
          for (int i = 0; i < CH; i++) m_data[i*W +: W] = m_q[i];
          m_fv = 1; m_q = {};
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    din_valid = v; sof = s; din = d;
    @(posedge clk);
    model_step(v, s, d);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 8'hC1); drive(1, 0, 8'hC2); drive(1, 0, 8'hC3); drive(1, 0, 8'hC4);
    drive(1, 1, 8'hD1);
    #2 rst_n = 0;
    #1;
    model_reset();
    n_chk++;
    if ({ch_data, slot, locked, frame_valid, sync_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got data=%h slot=%0d locked=%b fv=%b err=%b want all zero",
               ch_data, slot, locked, frame_valid, sync_err);
    end
    rst_n = 1;
  endtask

  task automatic test_normal();
    logic [W-1:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, d[i]);
      n_chk++;
      if (slot !== 2'((i + 1) % 4) || frame_valid !== (i == 3)) begin
        n_fail++;
        $display("FAIL normal beat %0d: got slot=%0d fv=%b want slot=%0d fv=%b", i, slot, frame_valid, (i + 1) % 4, i == 3);
      end
    end
    n_chk++;
    if (ch_data !== 32'h44332211) begin
      n_fail++;
      $display("FAIL normal_data: got %h want 44332211", ch_data);
    end
    drive(0, 0, 8'hFF);
    n_chk++;
    if (frame_valid !== 0 || ch_data !== 32'h44332211 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL normal_hold: got fv=%b data=%h want fv=0 data=44332211", frame_valid, ch_data);
    end
  endtask

  task automatic test_gaps();
    logic [10:0][9:0] st = {
      {2'b11, 8'h01}, {2'b00, 8'h99}, {2'b10, 8'h02}, {2'b00, 8'h98}, {2'b01, 8'h97},
      {2'b10, 8'h03}, {2'b10, 8'h04}, {2'b11, 8'h05}, {2'b10, 8'h06}, {2'b10, 8'h07}, {2'b10, 8'h08}};
    int pulses = 0;
    for (int i = 10; i >= 0; i--) begin
      drive(st[i][9], st[i][8], st[i][7:0]);
      pulses += int'(frame_valid);
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL gaps beat %0d: got %h want %h", 10 - i, obs, exp_vec());
      end
      if (i == 4) begin
        n_chk++;
        if (ch_data !== 32'h04030201 || frame_valid !== 1) begin
          n_fail++;
          $display("FAIL gaps_frame_a: got %h fv=%b want 04030201 fv=1", ch_data, frame_valid);
        end
      end
    end
    n_chk++;
    if (ch_data !== 32'h08070605 || pulses != 2) begin
      n_fail++;
      $display("FAIL gaps_frame_b: got %h pulses=%0d want 08070605 pulses=2", ch_data, pulses);
    end
  endtask

  task automatic test_early_sof();
    logic [W-1:0] d[6] = '{8'hAA, 8'hBB, 8'h10, 8'h20, 8'h30, 8'h40};
    for (int i = 0; i < 6; i++) begin
      drive(1, i == 0 || i == 2, d[i]);
      n_chk++;
      if (sync_err !== (i == 2) || frame_valid !== (i == 5) || locked !== 1 || obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL early_sof beat %0d: got err=%b fv=%b locked=%b vec=%h want err=%b fv=%b locked=1 vec=%h",
                 i, sync_err, frame_valid, locked, obs, i == 2, i == 5, exp_vec());
      end
    end
    n_chk++;
    if (ch_data !== 32'h40302010) begin
      n_fail++;
      $display("FAIL early_sof_data: got %h want 40302010", ch_data);
    end
  endtask

  task automatic test_missing_sof();
    logic [9:0] st[8] = '{{2'b11, 8'h71}, {2'b10, 8'h72}, {2'b10, 8'h73}, {2'b10, 8'h74},
                          {2'b10, 8'h55}, {2'b10, 8'h66}, {2'b11, 8'h81}, {2'b10, 8'h82}};
    logic [1:0] want[8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b01};
    for (int i = 0; i < 8; i++) begin
      drive(st[i][9], st[i][8], st[i][7:0]);
      n_chk++;
      if ({sync_err, locked} !== want[i] || obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL missing_sof beat %0d: got err,locked=%b vec=%h want %b vec=%h", i, {sync_err, locked}, obs, want[i], exp_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1, 1, 8'hA1); drive(1, 0, 8'hA2);
    #2 rst_n = 0;
    #1 rst_n = 1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, 8'h31 + 8'(i));
      n_chk++;
      if (ch_data !== (i == 3 ? 32'h34333231 : 32'h0) || obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL mid_reset beat %0d: got %h vec=%h want vec=%h", i, ch_data, obs, exp_vec());
      end
`ifdef TDM_DEMUX_CH_STROBE_EN
      n_chk++;
      if (ch_strobe !== 4'(1 << i)) begin
        n_fail++;
        $display("FAIL mid_reset_strobe beat %0d: got %b want %b", i, ch_strobe, 4'(1 << i));
      end
`endif
    end
  endtask

  task automatic test_random();
    logic v, s;
    for (int i = 0; i < 400; i++) begin
      v = $urandom_range(99) < 80;
      s = $urandom_range(99) < (m_q.size() == 0 ? 85 : 8);
      drive(v, s, 8'($urandom));
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random beat %0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    #2;
    n_chk++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL power_on_reset: got %h want %h", obs, exp_vec());
    end
    rst_n = 1;
    test_reset();
    test_normal();
    test_gaps();
    test_early_sof();
    test_missing_sof();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
